// File: rtl/fsm_avg_pkg.sv
// Shared types and helpers for the windowed-average sequencer.
package fsm_avg_pkg;

  // Sequencer states, in the order a window walks through them.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    WAIT  = 3'd2,
    SUM   = 3'd3,
    DONE  = 3'd4
  } avg_state_t;

  // The accumulator needs LOG2_N extra bits above the sample width so that
  // 2**LOG2_N full-scale samples can never wrap it.
  function automatic int acc_width(input int width, input int log2_n);
    return width + log2_n;
  endfunction

endpackage

// File: rtl/avg_accum.sv
// Sample accumulator and sample counter for one averaging window.
module avg_accum
  import fsm_avg_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int LOG2_N = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clr,
  input  logic                                  en,
  input  logic [WIDTH-1:0]                      din,
  output logic [acc_width(WIDTH, LOG2_N)-1:0]   acc,
  output logic [LOG2_N:0]                       cnt
);

  localparam int ACC_W = acc_width(WIDTH, LOG2_N);
  localparam int CNT_W = LOG2_N + 1;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over accumulate; otherwise add one sample and count it.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(din);
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Accumulator and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc = acc_q;
  assign cnt = cnt_q;

endmodule

// File: rtl/fsm_avg_ctrl.sv
// Windowed-average sequencer: accumulates 2**LOG2_N ticked samples and
// publishes their truncated mean with a one-cycle valid strobe.
module fsm_avg_ctrl
  import fsm_avg_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int LOG2_N = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sec,
  input  logic [WIDTH-1:0]  sample_in,
  input  logic              start,
  input  logic              mode_cont,
  output logic              busy,
  output logic              en_sum,
  output logic              rst_sum,
  output logic [WIDTH-1:0]  avg_out,
  output logic              avg_valid,
  output logic [LOG2_N:0]   sample_cnt
);

  localparam int ACC_W = acc_width(WIDTH, LOG2_N);
  localparam int CNT_W = LOG2_N + 1;
  // Counter value seen in the SUM cycle that takes the last sample of a window.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

  avg_state_t       state_q, state_d;
  logic [WIDTH-1:0] avg_q, avg_d;
  logic             valid_q, valid_d;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  // The accumulator is held cleared whenever the sequencer signals rst_sum,
  // so a fresh window always starts from zero.
  avg_accum #(
    .WIDTH  (WIDTH),
    .LOG2_N (LOG2_N)
  ) u_accum (
    .clk (clk),
    .rst (rst),
    .clr (rst_sum),
    .en  (en_sum),
    .din (sample_in),
    .acc (acc),
    .cnt (cnt)
  );

  // Next-state and state-decoded control outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    en_sum  = 1'b0;
    rst_sum = 1'b0;
    case (state_q)
      IDLE: begin
        busy    = 1'b0;
        rst_sum = 1'b1;
        if (start || mode_cont) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        rst_sum = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (sec) begin
          state_d = SUM;
        end
      end
      SUM: begin
        en_sum = 1'b1;
        if (cnt == CNT_LAST) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        if (mode_cont) begin
          state_d = CLEAR;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Result path: divide by the window length with a right shift in DONE and
  // raise the strobe for exactly the following cycle.
  always_comb begin
    avg_d   = avg_q;
    valid_d = 1'b0;
    if (state_q == DONE) begin
      avg_d   = WIDTH'(acc >> LOG2_N);
      valid_d = 1'b1;
    end
  end

  // State and result registers; reset aborts any window without a strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      avg_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      avg_q   <= avg_d;
      valid_q <= valid_d;
    end
  end

  assign avg_out    = avg_q;
  assign avg_valid  = valid_q;
  assign sample_cnt = cnt;

endmodule
